// File: rtl/exe_conv_pkg.sv
// exe_conv_pkg: shared types and constants for the execution/conversion unit arbiter
package exe_conv_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int CNT_W = 4;
  typedef logic req_id_t;
endpackage

// File: rtl/exe_conv_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; the pointer names the favoured requester under contention
module rr_arb2
  import exe_conv_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  req_id_t    pointer,
  input  logic       enable,
  output logic [1:0] grant
);
  always_comb begin
    grant[0] = enable & valid0 & (~valid1 | ~pointer);
    grant[1] = enable & valid1 & (~valid0 | pointer);
  end
endmodule

// File: rtl/exe_conv_arbiter.sv
// exe_conv_arbiter: time-shares one combinational conversion unit between two requesters
module exe_conv_arbiter
  import exe_conv_pkg::*;
#(
  parameter int BITS = 8,
  parameter int LAT  = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid0,
  input  logic [BITS-1:0] i_argA0,
  input  logic [BITS-1:0] i_argB0,
  output logic            o_ready0,
  input  logic            i_valid1,
  input  logic [BITS-1:0] i_argA1,
  input  logic [BITS-1:0] i_argB1,
  output logic            o_ready1,
  output logic [BITS-1:0] o_unit_argA,
  output logic [BITS-1:0] o_unit_argB,
  input  logic [BITS-1:0] i_unit_result,
  output logic [BITS-1:0] o_result,
  output logic            o_rsp_id,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic            o_busy
);
  state_t           state_q, state_d;
  req_id_t          ptr_q, ptr_d, id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BITS-1:0]  arg_a_q, arg_a_d, arg_b_q, arg_b_d, result_q, result_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       grant;

  rr_arb2 u_arb (
    .valid0  (i_valid0),
    .valid1  (i_valid1),
    .pointer (ptr_q),
    .enable  (state_q == IDLE),
    .grant   (grant)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    arg_a_d     = arg_a_q;
    arg_b_d     = arg_b_q;
    result_d    = result_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: if (|grant) begin
        arg_a_d = grant[1] ? i_argA1 : i_argA0;
        arg_b_d = grant[1] ? i_argB1 : i_argB0;
        id_d    = grant[1];
        cnt_d   = CNT_W'(LAT - 1);
        ptr_d   = ~ptr_q;
        state_d = BUSY;
      end
      BUSY: if (cnt_q == '0) begin
        result_d    = i_unit_result;
        rsp_valid_d = 1'b1;
        state_d     = DONE;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      DONE: if (i_rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      arg_a_q     <= '0;
      arg_b_q     <= '0;
      result_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      arg_a_q     <= arg_a_d;
      arg_b_q     <= arg_b_d;
      result_q    <= result_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign o_ready0    = grant[0];
  assign o_ready1    = grant[1];
  assign o_unit_argA = arg_a_q;
  assign o_unit_argB = arg_b_q;
  assign o_result    = result_q;
  assign o_rsp_id    = id_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_busy      = state_q != IDLE;
endmodule

// File: tb/tb_exe_conv_arbiter.sv
// tb_exe_conv_arbiter: directed vector table plus hand-written corner sequences for LAT=2 and LAT=1 builds
module tb_exe_conv_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1, rr;
  logic [7:0] a0, a1, b0, b1;
  logic       r0, r1, rv, busy, id;
  logic [7:0] ua, ub, res, ures;
  logic       p_r0, p_r1, p_rv, p_busy, p_id;
  logic [7:0] p_ua, p_ub, p_res, p_ures;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign ures   = ua[7] ? ua + 8'd1 : ua;
  assign p_ures = p_ua[7] ? p_ua + 8'd1 : p_ua;

  exe_conv_arbiter #(.BITS(8), .LAT(2)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_valid0(v0), .i_argA0(a0), .i_argB0(b0), .o_ready0(r0),
    .i_valid1(v1), .i_argA1(a1), .i_argB1(b1), .o_ready1(r1),
    .o_unit_argA(ua), .o_unit_argB(ub), .i_unit_result(ures),
    .o_result(res), .o_rsp_id(id), .o_rsp_valid(rv), .i_rsp_ready(rr), .o_busy(busy)
  );

  exe_conv_arbiter #(.BITS(8), .LAT(1)) dut1 (
    .i_clk(clk), .i_rst(rst),
    .i_valid0(v0), .i_argA0(a0), .i_argB0(b0), .o_ready0(p_r0),
    .i_valid1(v1), .i_argA1(a1), .i_argB1(b1), .o_ready1(p_r1),
    .o_unit_argA(p_ua), .o_unit_argB(p_ub), .i_unit_result(p_ures),
    .o_result(p_res), .o_rsp_id(p_id), .o_rsp_valid(p_rv), .i_rsp_ready(rr), .o_busy(p_busy)
  );

  typedef struct {
    logic       v0;
    logic [7:0] a0;
    logic       v1;
    logic [7:0] a1;
    logic       rr;
    logic       er0, er1, erv, ebusy, eid;
    logic [7:0] eres, eua;
  } vec_t;

  vec_t tbl [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; v0 = 0; v1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; rr = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic seen;
    tbl[0]  = '{1, 8'hFE, 0, 8'h00, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00};
    tbl[1]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 8'hFE};
    tbl[2]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00, 8'hFE};
    tbl[3]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 0, 8'hFF, 8'hFE};
    tbl[4]  = '{0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 0, 8'hFF, 8'hFE};
    tbl[5]  = '{1, 8'h05, 1, 8'h85, 1, 1, 0, 0, 0, 0, 8'h00, 8'h00};
    tbl[6]  = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 0, 1, 0, 8'h00, 8'h05};
    tbl[7]  = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 0, 1, 0, 8'h00, 8'h05};
    tbl[8]  = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 1, 1, 0, 8'h05, 8'h05};
    tbl[9]  = '{1, 8'h05, 1, 8'h85, 1, 0, 1, 0, 0, 0, 8'h05, 8'h05};
    tbl[10] = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 0, 1, 1, 8'h05, 8'h85};
    tbl[11] = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 0, 1, 1, 8'h05, 8'h85};
    tbl[12] = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 1, 1, 1, 8'h86, 8'h85};
    tbl[13] = '{1, 8'h05, 1, 8'h85, 1, 1, 0, 0, 0, 1, 8'h86, 8'h85};
    tbl[14] = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 0, 1, 0, 8'h86, 8'h05};
    tbl[15] = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 0, 1, 0, 8'h86, 8'h05};
    tbl[16] = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 1, 1, 0, 8'h05, 8'h05};
    tbl[17] = '{1, 8'h05, 1, 8'h85, 1, 0, 1, 0, 0, 0, 8'h05, 8'h05};
    tbl[18] = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 0, 1, 1, 8'h05, 8'h85};
    tbl[19] = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 0, 1, 1, 8'h05, 8'h85};
    tbl[20] = '{1, 8'h05, 1, 8'h85, 1, 0, 0, 1, 1, 1, 8'h86, 8'h85};

    do_reset();
    chk("reset_state", {r0, r1, rv, busy, id, res, ua, ub}, 32'h0);

    // single request (rows 0-4) and contention alternation (rows 5-20)
    for (int i = 0; i < 21; i++) begin
      if (i == 5) do_reset();
      v0 = tbl[i].v0; a0 = tbl[i].a0; v1 = tbl[i].v1; a1 = tbl[i].a1; rr = tbl[i].rr;
      #1;
      chk($sformatf("vec%0d", i), {r0, r1, rv, busy, id, res, ua},
          {tbl[i].er0, tbl[i].er1, tbl[i].erv, tbl[i].ebusy, tbl[i].eid, tbl[i].eres, tbl[i].eua});
      step();
    end

    // response stall
    do_reset();
    v0 = 1; a0 = 8'h05; v1 = 1; a1 = 8'h85; rr = 0;
    step();
    v0 = 0;
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("stall%0d", i), {r0, r1, rv, busy, id, res}, {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h05});
      step();
    end
    rr = 1;
    #1;
    chk("stall_release_noready", {r0, r1}, 2'b00);
    step();
    chk("stall_req1_grant", {r0, r1, rv, busy}, 4'b0100);
    step();
    v1 = 0;
    step();
    step();
    chk("stall_req1_result", {rv, id, res}, {1'b1, 1'b1, 8'h86});
    step();

    // reset in the first BUSY cycle
    do_reset();
    v0 = 1; a0 = 8'h7F;
    step();
    v0 = 0;
    chk("rst_busy_pre", busy, 1'b1);
    rst = 1;
    step();
    rst = 0;
    chk("rst_busy_clear", {r0, r1, rv, busy, id, res, ua, ub}, 32'h0);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      seen |= rv;
      step();
    end
    chk("rst_busy_no_rsp", seen, 1'b0);
    v0 = 1; a0 = 8'h11; v1 = 1; a1 = 8'h22;
    #1;
    chk("rst_ptr_req0", {r0, r1}, 2'b10);

    // valid withdrawal while DONE
    do_reset();
    v0 = 1; a0 = 8'h05;
    step();
    v0 = 0;
    step();
    step();
    v1 = 1; a1 = 8'h99;
    #1;
    chk("wd_done_noready", {r0, r1, rv}, 3'b001);
    step();
    v1 = 0; v0 = 1; a0 = 8'h83; rr = 1;
    step();
    rr = 0;
    chk("wd_idle_grant", {r0, r1, busy}, 3'b100);
    step();
    v0 = 0;
    step();
    step();
    chk("wd_result", {rv, id, res, ua}, {1'b1, 1'b0, 8'h84, 8'h83});

    // LAT=1 build
    do_reset();
    v0 = 1; a0 = 8'h80;
    #1;
    chk("lat1_ready", p_r0, 1'b1);
    step();
    v0 = 0;
    chk("lat1_busy", {p_busy, p_rv}, 2'b10);
    step();
    chk("lat1_rsp", {p_rv, p_id, p_res}, {1'b1, 1'b0, 8'h81});
    chk("lat2_still_busy", {busy, rv}, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/exe_conv_arbiter.md
Name: exe_conv_arbiter

Overview:
Shares one combinational execution/conversion unit (operand-in, result-out, e.g. the ones'-to-two's-complement converter) between two requesters in the SPI execution stage.
- Round-robin arbitration between the two requesters.
- Registers the winner's operands, holds them stable on the unit inputs for a fixed settle time, then captures the result.
- Returns the result tagged with the requester ID via a valid/ready response handshake.

Parameters:
BITS, 8, operand/result width.
LAT, 2, unit settle cycles before result capture; legal range 1..15.

Ports:
i_clk  in  1  clock, all state updates on rising edge.
i_rst  in  1  synchronous active-high reset.
i_valid0  in  1  requester 0 has an operation.
i_argA0  in  BITS  requester 0 operand A.
i_argB0  in  BITS  requester 0 operand B.
o_ready0  out  1  requester 0 accepted this cycle when high with i_valid0.
i_valid1  in  1  requester 1 has an operation.
i_argA1  in  BITS  requester 1 operand A.
i_argB1  in  BITS  requester 1 operand B.
o_ready1  out  1  requester 1 accepted this cycle when high with i_valid1.
o_unit_argA  out  BITS  registered operand A to shared unit.
o_unit_argB  out  BITS  registered operand B to shared unit.
i_unit_result  in  BITS  shared unit result.
o_result  out  BITS  captured result.
o_rsp_id  out  1  requester that owns o_result.
o_rsp_valid  out  1  response valid.
i_rsp_ready  in  1  consumer accepts response.
o_busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - state=IDLE.
  - o_unit_argA=0, o_unit_argB=0, o_result=0, o_rsp_id=0.
  - o_rsp_valid=0, o_busy=0.
  - priority pointer = requester 0; settle counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - o_readyX is combinational and asserted only in IDLE, for the arbitration winner only, and only when that requester's i_validX is high.
  - Winner when both are valid: the requester named by the priority pointer.
  - Winner when only one is valid: that requester.
  - On accept (i_validX && o_readyX):
    - latch argA/argB into o_unit_argA/B;
    - latch X into o_rsp_id;
    - load counter with LAT-1;
    - toggle the priority pointer to the other requester, whether or not there was contention;
    - go to BUSY.
  - With no valid request, remain in IDLE.
- BUSY:
  - Operands are held constant; both o_readyX are 0.
  - Counter decrements each cycle.
  - In the cycle the counter is 0: o_result <= i_unit_result, o_rsp_valid <= 1, go to DONE.
- DONE:
  - o_rsp_valid, o_result and o_rsp_id are held stable until i_rsp_ready=1.
  - On i_rsp_ready=1: o_rsp_valid <= 0, go to IDLE.
  - No new accept occurs in the same cycle as the response handshake.
- Timing:
  - Accept on edge N: BUSY covers cycles N+1..N+LAT; o_rsp_valid rises at N+LAT+1.
  - Minimum issue interval is LAT+2 cycles (i_rsp_ready tied high).
- Boundary conditions:
  - LAT=1: exactly one BUSY cycle.
  - Response consumer stalls indefinitely: the block holds DONE; both readies stay 0, so requesters are back-pressured.
  - i_validX deasserted while not ready: nothing is captured; no request is remembered.
  - i_rst mid-BUSY or mid-DONE: the in-flight operation is discarded and no response is emitted; the next cycle is IDLE with reset values.
  - o_unit_argA/B keep the last operands after completion; they are only changed by an accept or a reset.
  - Width: results pass through untouched (BITS in, BITS out); no arithmetic is done in this block.

Decomposition:
- Package exe_conv_pkg:
  - state enum (IDLE/BUSY/DONE, 2-bit);
  - localparam CNT_W=4 for the settle counter;
  - requester ID typedef (1 bit).
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: valid0, valid1, pointer, enable.
  - Outputs: one-hot grant.
  - Enable is (state==IDLE).
  - The parent owns the pointer update.

Test Plan:
All scenarios use BITS=8, LAT=2, with the conversion unit (add 1 when MSB set) wired to o_unit_argA/i_unit_result.
1. Single request. Req0 valid, argA=0xFE, accepted at cycle 0 -> o_busy=1 for cycles 1-2, o_rsp_valid=1 at cycle 3 with o_result=0xFF, o_rsp_id=0; i_rsp_ready=1 -> IDLE at cycle 4.
2. Contention alternation. Both valid continuously (req0 argA=0x05, req1 argA=0x85), i_rsp_ready=1:
   - grants alternate 0,1,0,1 with results 0x05, 0x86, 0x05, 0x86;
   - issue interval 4 cycles.
3. Response stall. i_rsp_ready=0 for 10 cycles after the response ->
   - o_rsp_valid, o_result and o_rsp_id stay stable;
   - o_ready0/o_ready1 stay 0 throughout;
   - the pending req1 is accepted only after ready.
4. Reset mid-BUSY. Pulse i_rst in cycle 1 of BUSY ->
   - no o_rsp_valid ever appears;
   - all outputs 0;
   - the next simultaneous request is granted to req0 (pointer reset).
5. Valid withdrawal. i_valid1 asserted one cycle while DONE, then dropped -> no accept of req1; the next IDLE grants the remaining valid requester only.
6. LAT=1 build. Req0 argA=0x80 -> o_rsp_valid two cycles after accept with o_result=0x81.
